// File: rtl/spi_command_rx.sv
// spi_command_rx: SPI mode-0 slave turning host command bytes into FIFO write strobes.
// Define SPI_STATUS_READBACK_EN to return a status byte on spi_miso.
module spi_command_rx #(
  parameter int sync_stages      = 2,
  parameter int fifo_count_width = 6,
  parameter int fifo_limit       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_sck,
  input  logic                        spi_cs_n,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  input  logic [fifo_count_width-1:0] fifo_count,
  input  logic                        invalid_command,
  output logic [7:0]                  command_out,
  output logic                        command_out_ready,
  output logic                        overrun,
  output logic                        frame_active
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q;
  logic [sync_stages-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_s, cs_s, mosi_s;
  logic sck_d_q, rise_q, cs_q, mosi_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, command_out_q;
  logic command_out_ready_q, overrun_q, invalid_seen_q;
  logic fifo_ok;
  assign sck_s  = sck_sync_q[sync_stages-1];
  assign cs_s   = cs_sync_q[sync_stages-1];
  assign mosi_s = mosi_sync_q[sync_stages-1];
  assign fifo_ok = 32'(fifo_count) < 32'(fifo_limit);
`ifdef SPI_STATUS_READBACK_EN
  logic fall_q;
  logic [7:0] status_q, status_w;
  assign status_w = {invalid_seen_q, overrun_q, (32'(fifo_count) > 32'd63) ? 6'd63 : 6'(fifo_count)};
  assign spi_miso = status_q[7];
`else
  logic unused_invalid;
  assign unused_invalid = invalid_seen_q;
  assign spi_miso = 1'b0;
`endif
  // Edge flags and data are registered together so the FSM sees them aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_d_q     <= 1'b0;
      rise_q      <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
`ifdef SPI_STATUS_READBACK_EN
      fall_q      <= 1'b0;
`endif
    end else begin
      sck_sync_q  <= {sck_sync_q[sync_stages-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[sync_stages-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[sync_stages-2:0], spi_mosi};
      sck_d_q     <= sck_s;
      rise_q      <= sck_s & ~sck_d_q;
      cs_q        <= cs_s;
      mosi_q      <= mosi_s;
`ifdef SPI_STATUS_READBACK_EN
      fall_q      <= ~sck_s & sck_d_q;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      bit_cnt_q           <= 3'd0;
      shift_q             <= 8'd0;
      command_out_q       <= 8'd0;
      command_out_ready_q <= 1'b0;
      overrun_q           <= 1'b0;
      invalid_seen_q      <= 1'b0;
`ifdef SPI_STATUS_READBACK_EN
      status_q            <= 8'd0;
`endif
    end else begin
      command_out_ready_q <= 1'b0;
      invalid_seen_q      <= invalid_seen_q | invalid_command;
      if (cs_q) begin
        state_q   <= IDLE;
        bit_cnt_q <= 3'd0;
        shift_q   <= 8'd0;
`ifdef SPI_STATUS_READBACK_EN
        status_q  <= 8'd0;
`endif
      end else if (state_q == IDLE) begin
        state_q  <= ACTIVE;
`ifdef SPI_STATUS_READBACK_EN
        status_q <= status_w;
`endif
      end else if (rise_q) begin
        shift_q   <= {shift_q[6:0], mosi_q};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (fifo_ok) begin
            command_out_q       <= {shift_q[6:0], mosi_q};
            command_out_ready_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
`ifdef SPI_STATUS_READBACK_EN
          status_q <= status_w;
`endif
        end
      end
`ifdef SPI_STATUS_READBACK_EN
      // The fall right after a byte wrap must not consume the freshly loaded MSB.
      else if (fall_q && bit_cnt_q != 3'd0) begin
        status_q <= {status_q[6:0], 1'b0};
      end
`endif
    end
  end
  assign command_out       = command_out_q;
  assign command_out_ready = command_out_ready_q;
  assign overrun           = overrun_q;
  assign frame_active      = ~cs_s;
endmodule

// File: tb/tb_spi_command_rx.sv
// tb_spi_command_rx: randomized host-side stimulus checked against a byte-queue model.
module tb_spi_command_rx;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic reset, spi_sck, spi_cs_n, spi_mosi, spi_miso, invalid_command;
  logic [5:0] fifo_count;
  logic [7:0] command_out;
  logic command_out_ready, overrun, frame_active;
  int checks = 0, errors = 0, cyc = 0, last_rise_cyc = 0;
  logic [7:0] got_q[$];
  int got_cyc[$];
  logic [7:0] miso_byte = 8'd0;
  logic miso_bad = 1'b0;

  spi_command_rx #(.sync_stages(SS), .fifo_count_width(6), .fifo_limit(32)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .fifo_count(fifo_count), .invalid_command(invalid_command),
    .command_out(command_out), .command_out_ready(command_out_ready), .overrun(overrun),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (command_out_ready) begin
      got_q.push_back(command_out);
      got_cyc.push_back(cyc);
    end
`ifndef SPI_STATUS_READBACK_EN
    if (spi_miso !== 1'b0) miso_bad = 1'b1;
`endif
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host drives MOSI while SCK is low, samples MISO just before each rise.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      wait_n(8);
      miso_byte = {miso_byte[6:0], spi_miso};
      spi_sck = 1'b1;
      last_rise_cyc = cyc;
      wait_n(8);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_n(8);
  endtask

  task automatic cs_high();
    wait_n(8);
    spi_cs_n = 1'b1;
    wait_n(8);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_n(2);
    reset = 1'b0;
    wait_n(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    invalid_command = 1'b0; fifo_count = 6'd0;
    wait_n(3);
    checks++; if (command_out !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h want 00", command_out); end
    checks++; if (command_out_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", command_out_ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_fa: got %b want 0", frame_active); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
    reset = 1'b0;
    wait_n(2);
  endtask

  task automatic test_single();
    got_q.delete(); got_cyc.delete();
    spi_cs_n = 1'b0;
    wait_n(1);
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL fa_early: got %b want 0", frame_active); end
    wait_n(SS - 1);
    checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL fa_latency: got %b want 1", frame_active); end
    wait_n(6);
    send_bits(8'hA5, 8);
    cs_high();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_val: got %h want a5", got_q[0]); end
      checks++; if (got_cyc[0] - last_rise_cyc != SS + 2) begin errors++; $display("FAIL single_lat: got %0d want %0d", got_cyc[0] - last_rise_cyc, SS + 2); end
    end
    checks++; if (command_out !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h want a5", command_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_ovr: got %b want 0", overrun); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL fa_release: got %b want 0", frame_active); end
  endtask

  task automatic test_multi();
    logic [7:0] exp [3];
    exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF;
    got_q.delete(); got_cyc.delete();
    cs_low();
    for (int k = 0; k < 3; k++) send_bits(exp[k], 8);
    cs_high();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL multi_count: got %0d want 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp[k]) begin errors++; $display("FAIL multi_val%0d: got %h want %h", k, got_q[k], exp[k]); end
    end
    if (got_q.size() == 3) begin
      checks++; if (got_cyc[1] - got_cyc[0] != 128) begin errors++; $display("FAIL multi_spacing: got %0d want 128", got_cyc[1] - got_cyc[0]); end
    end
  endtask

  task automatic test_fragment();
    got_q.delete(); got_cyc.delete();
    cs_low();
    send_bits(8'hB7, 5);
    cs_high();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL frag_count: got %0d want 0", got_q.size()); end
    cs_low();
    send_bits(8'h3C, 8);
    cs_high();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL frag_next_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h3C) begin errors++; $display("FAIL frag_next_val: got %h want 3c", got_q[0]); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL frag_ovr: got %b want 0", overrun); end
  endtask

  task automatic test_overrun();
    got_q.delete(); got_cyc.delete();
    fifo_count = 6'd32;
    cs_low();
    send_bits(8'h12, 8);
    cs_high();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovr_drop: got %0d strobes want 0", got_q.size()); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    checks++; if (command_out !== 8'h3C) begin errors++; $display("FAIL ovr_hold: got %h want 3c", command_out); end
    fifo_count = 6'd0;
    cs_low();
    send_bits(8'h34, 8);
    cs_high();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ovr_next_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h34) begin errors++; $display("FAIL ovr_next_val: got %h want 34", got_q[0]); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); got_cyc.delete();
    cs_low();
    send_bits(8'hF0, 4);
    reset = 1'b1;
    wait_n(1);
    checks++; if (command_out !== 8'h00) begin errors++; $display("FAIL rmid_cmd: got %h want 00", command_out); end
    checks++; if (command_out_ready !== 1'b0) begin errors++; $display("FAIL rmid_rdy: got %b want 0", command_out_ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_ovr: got %b want 0", overrun); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL rmid_fa: got %b want 0", frame_active); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rmid_miso: got %b want 0", spi_miso); end
    reset = 1'b0;
    cs_high();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rmid_nostrobe: got %0d want 0", got_q.size()); end
    cs_low();
    send_bits(8'h0F, 8);
    cs_high();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rmid_next_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h0F) begin errors++; $display("FAIL rmid_next_val: got %h want 0f", got_q[0]); end
    end
  endtask

  // Model: a full byte is accepted iff the occupancy is below 32; otherwise overrun sticks.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic exp_ov;
    logic [7:0] b;
    int fc, nb;
    do_reset();
    got_q.delete(); got_cyc.delete();
    exp_ov = 1'b0;
    for (int f = 0; f < 12; f++) begin
      cs_low();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        fc = $urandom_range(0, 1) ? $urandom_range(0, 40) : ($urandom_range(0, 1) ? 31 : 32);
        fifo_count = 6'(fc);
        if (fc < 32) exp_q.push_back(b);
        else exp_ov = 1'b1;
        send_bits(b, 8);
      end
      if ($urandom_range(0, 2) == 0) send_bits(8'($urandom), $urandom_range(1, 7));
      cs_high();
    end
    fifo_count = 6'd0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_val%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overrun !== exp_ov) begin errors++; $display("FAIL rand_ovr: got %b want %b", overrun, exp_ov); end
  endtask

`ifdef SPI_STATUS_READBACK_EN
  task automatic test_readback();
    do_reset();
    invalid_command = 1'b1;
    wait_n(1);
    invalid_command = 1'b0;
    fifo_count = 6'd5;
    cs_low();
    miso_byte = 8'd0;
    send_bits(8'h00, 8);
    checks++; if (miso_byte !== 8'h85) begin errors++; $display("FAIL rb_first: got %h want 85", miso_byte); end
    miso_byte = 8'd0;
    send_bits(8'h00, 8);
    checks++; if (miso_byte !== 8'h85) begin errors++; $display("FAIL rb_second: got %h want 85", miso_byte); end
    cs_high();
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rb_idle: got %b want 0", spi_miso); end
    fifo_count = 6'd0;
  endtask
`else
  task automatic test_miso_zero();
    checks++; if (miso_bad !== 1'b0) begin errors++; $display("FAIL miso_tied: got %b want 0", miso_bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_fragment();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef SPI_STATUS_READBACK_EN
    test_readback();
`else
    test_miso_zero();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
